// File: rtl/rx_pkg.sv
// Shared Rx-chain definitions.
// - subc_class_t : subcarrier class tag produced by the demapper
// - ss_decode()  : maps the SS index onto log2(spreading factor) plus an illegal flag
// - SS_MAX       : largest spreading factor, which sizes the group counter
package rx_pkg;

    typedef enum logic [1:0] {
        SC_NULL  = 2'd0,
        SC_DATA  = 2'd1,
        SC_PILOT = 2'd2,
        SC_GUARD = 2'd3
    } subc_class_t;

    localparam int SS_MAX = 4;

    typedef struct packed {
        logic [1:0] shift;    // log2(N)
        logic       illegal;
    } ss_dec_t;

    // 0 -> x1, 1 -> x2, 3 -> x4; any other code falls back to x1 and is flagged.
    function automatic ss_dec_t ss_decode(input logic [3:0] ss);
        ss_dec_t r;
        r.shift   = 2'd0;
        r.illegal = 1'b0;
        case (ss)
            4'd0:    r.shift = 2'd0;
            4'd1:    r.shift = 2'd1;
            4'd3:    r.shift = 2'd2;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst (async, active-low)
//   push/din  : write request and data; accepted when not full, or when full with a pop
//   pop       : read request; dout always shows the head word while !empty
//   empty/full: occupancy flags
module sync_fifo_fwft #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/subc_despreader.sv
// Subcarrier despreader: drops null/guard (and, by default, pilot) subcarriers, averages
// groups of 1/2/4 data copies and queues the result towards the soft demodulator.
// Ports:
//   clk, rst (async, active-low)
//   ival/isop/isof/iindex_subc/isubc_i/isubc_q/index_SS_in/index_M_in : tagged input stream
//   oready                  : downstream ready
//   oval/osubc_i/osubc_q/index_M_out/osop/osof : FWFT output word (all zero while !oval)
//   err_ss                  : sticky, illegal SS code seen on a data sample
//   ovf                     : sticky, word dropped because the FIFO was full
// Build option PILOT_OUT_EN adds opilot_val/opilot_i/opilot_q/opilot_sop, a registered copy
// of class-2 samples; without it pilots are simply dropped.
module subc_despreader
    import rx_pkg::*;
#(
    parameter int fft_depth  = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ival,
    input  logic                 isop,
    input  logic                 isof,
    input  logic [1:0]           iindex_subc,
    input  logic [fft_depth-1:0] isubc_i,
    input  logic [fft_depth-1:0] isubc_q,
    input  logic [3:0]           index_SS_in,
    input  logic [2:0]           index_M_in,
    input  logic                 oready,
    output logic                 oval,
    output logic [fft_depth-1:0] osubc_i,
    output logic [fft_depth-1:0] osubc_q,
    output logic [2:0]           index_M_out,
    output logic                 osop,
    output logic                 osof,
`ifdef PILOT_OUT_EN
    output logic                 opilot_val,
    output logic [fft_depth-1:0] opilot_i,
    output logic [fft_depth-1:0] opilot_q,
    output logic                 opilot_sop,
`endif
    output logic                 err_ss,
    output logic                 ovf
);

    localparam int AccW  = fft_depth + 2;
    localparam int CntW  = $clog2(SS_MAX);
    localparam int WordW = 2 * fft_depth + 5;

    typedef logic signed [AccW-1:0] acc_t;

    // Group state
    logic [CntW-1:0] cnt_q;
    logic [1:0]      shift_q;
    logic [2:0]      m_q;
    acc_t            acc_i_q, acc_q_q;
    logic            pend_sop_q, pend_sof_q;
    logic            pend_sop_d, pend_sof_d;

    // Result stage feeding the FIFO
    logic                 push_q;
    logic [fft_depth-1:0] res_i_q, res_q_q;
    logic [2:0]           res_m_q;

    logic err_ss_q, ovf_q;

    // Current-sample decode
    logic            sop_fire, is_data, first, last;
    ss_dec_t         ss_dec;
    logic [1:0]      shift_eff;
    logic [2:0]      m_eff;
    logic [CntW-1:0] cnt_cur, n_last;
    acc_t            in_i, in_q, sum_i, sum_q;

    logic             fifo_pop, fifo_empty, fifo_full;
    logic [WordW-1:0] fifo_din, fifo_dout;

    always_comb begin
        sop_fire  = ival && isop;
        is_data   = ival && (subc_class_t'(iindex_subc) == SC_DATA);
        ss_dec    = ss_decode(index_SS_in);
        // isop restarts grouping, so its own sample is always copy 0.
        first     = sop_fire || (cnt_q == '0);
        cnt_cur   = first ? '0 : cnt_q;
        shift_eff = first ? ss_dec.shift : shift_q;
        m_eff     = first ? index_M_in : m_q;
        n_last    = CntW'((32'd1 << shift_eff) - 32'd1);
        last      = is_data && (cnt_cur == n_last);
        in_i      = acc_t'($signed(isubc_i));
        in_q      = acc_t'($signed(isubc_q));
        sum_i     = first ? in_i : acc_i_q + in_i;
        sum_q     = first ? in_q : acc_q_q + in_q;
    end

    // A write consumes the pending flags, but a fresh isop in the same cycle re-arms them
    // for the next symbol.
    always_comb begin
        pend_sop_d = push_q ? 1'b0 : pend_sop_q;
        pend_sof_d = push_q ? 1'b0 : pend_sof_q;
        if (sop_fire) begin
            pend_sop_d = 1'b1;
            if (isof) pend_sof_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            m_q        <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            pend_sop_q <= 1'b0;
            pend_sof_q <= 1'b0;
            push_q     <= 1'b0;
            res_i_q    <= '0;
            res_q_q    <= '0;
            res_m_q    <= '0;
            err_ss_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pend_sop_q <= pend_sop_d;
            pend_sof_q <= pend_sof_d;
            push_q     <= last;
            if (is_data) begin
                acc_i_q <= sum_i;
                acc_q_q <= sum_q;
                cnt_q   <= last ? '0 : cnt_cur + CntW'(1);
                if (first) begin
                    shift_q <= ss_dec.shift;
                    m_q     <= index_M_in;
                end
                if (ss_dec.illegal) err_ss_q <= 1'b1;
            end else if (sop_fire) begin
                cnt_q   <= '0;
                acc_i_q <= '0;
                acc_q_q <= '0;
            end
            if (last) begin
                // Arithmetic shift floors; the average always fits back into fft_depth bits.
                res_i_q <= fft_depth'(sum_i >>> shift_eff);
                res_q_q <= fft_depth'(sum_q >>> shift_eff);
                res_m_q <= m_eff;
            end
            if (push_q && fifo_full && !fifo_pop) ovf_q <= 1'b1;
        end
    end

    assign fifo_din = {res_i_q, res_q_q, res_m_q, pend_sop_q, pend_sof_q};
    assign fifo_pop = oval && oready;

    sync_fifo_fwft #(
        .WIDTH (WordW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Data outputs are forced to zero while empty so stale/unwritten RAM never shows.
    always_comb begin
        oval = !fifo_empty;
        {osubc_i, osubc_q, index_M_out, osop, osof} = oval ? fifo_dout : '0;
        err_ss = err_ss_q;
        ovf    = ovf_q;
    end

`ifdef PILOT_OUT_EN
    logic                 is_pilot;
    logic                 pilot_pend_q;
    logic                 opilot_val_q, opilot_sop_q;
    logic [fft_depth-1:0] opilot_i_q, opilot_q_q;

    assign is_pilot = ival && (subc_class_t'(iindex_subc) == SC_PILOT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pilot_pend_q <= 1'b0;
            opilot_val_q <= 1'b0;
            opilot_sop_q <= 1'b0;
            opilot_i_q   <= '0;
            opilot_q_q   <= '0;
        end else begin
            opilot_val_q <= is_pilot;
            opilot_sop_q <= is_pilot && (pilot_pend_q || sop_fire);
            if (is_pilot) begin
                opilot_i_q   <= isubc_i;
                opilot_q_q   <= isubc_q;
                pilot_pend_q <= 1'b0;
            end else if (sop_fire) begin
                pilot_pend_q <= 1'b1;
            end
        end
    end

    assign opilot_val = opilot_val_q;
    assign opilot_sop = opilot_sop_q;
    assign opilot_i   = opilot_i_q;
    assign opilot_q   = opilot_q_q;
`endif

endmodule
